// File: rtl/jesd204_soft_pcs_pkg.sv
// jesd204_soft_pcs_pkg
//   Shared constants and types for the JESD204 TX soft-PCS blocks:
//   10b symbol width, the two K28.5 comma encodings, the CGS/DATA
//   state encoding and a ones-count helper used for disparity checks.
package jesd204_soft_pcs_pkg;

    localparam int unsigned SYM_W = 10;

    // K28.5 sent at RD+ (4 ones, leaves RD-) and at RD- (6 ones, leaves RD+)
    localparam logic [SYM_W-1:0] PATTERN_P = 10'b1010000011;
    localparam logic [SYM_W-1:0] PATTERN_N = 10'b0101111100;

    typedef enum logic {
        ST_CGS  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    function automatic logic [3:0] ones_count(input logic [SYM_W-1:0] s);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            n = n + {3'b000, s[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/jesd204_disparity_track.sv
// jesd204_disparity_track
//   Combinational running-disparity step for one 10b symbol.
//   Ports:
//     i_sym  - 10b symbol
//     i_rd   - running disparity before the symbol (1 = RD+)
//     o_rd   - running disparity after the symbol
//     o_err  - symbol is illegal for i_rd (bad weight or wrong-polarity
//              unbalanced symbol)
module jesd204_disparity_track
    import jesd204_soft_pcs_pkg::*;
(
    input  logic [SYM_W-1:0] i_sym,
    input  logic             i_rd,
    output logic             o_rd,
    output logic             o_err
);

    logic [3:0] w_ones;

    always_comb begin
        w_ones = ones_count(i_sym);
        o_rd   = i_rd;
        if (w_ones >= 4'd6) begin
            o_rd = 1'b1;
        end else if (w_ones <= 4'd4) begin
            o_rd = 1'b0;
        end
        o_err = (w_ones < 4'd4) || (w_ones > 4'd6) ||
                ((w_ones == 4'd6) && i_rd) ||
                ((w_ones == 4'd4) && !i_rd);
    end

endmodule

// File: rtl/jesd204_tx_comma_gen.sv
// jesd204_tx_comma_gen
//   TX soft-PCS stage between the 8b10b encoder and the serializer.
//   In CGS it emits RD-correct K28.5 commas in every slot; in DATA it
//   forwards encoded symbols (idle-filling with commas when no input is
//   valid), tracks running disparity and flags disparity violations.
//   Optional macro JESD204_TX_COMMA_BITSLIP_EN adds slip_shift, a per-symbol
//   right rotation of out_data (test aid for RX aligners).
//   Ports:
//     clk, resetn    - clock, asynchronous active-low reset
//     cgs_req        - 1 = request/hold CGS, 0 = permit DATA
//     min_cgs_beats  - minimum number of comma beats per CGS phase
//     in_data/valid  - encoded symbols in (slot 0 in [9:0]) / valid
//     in_ready       - input accepted this cycle (high in DATA)
//     out_data       - registered symbols to the serializer
//     cgs_active     - high while in CGS
//     rd_out         - running disparity after last emitted symbol
//     disparity_err  - one-beat pulse on a forwarded RD violation
//     slip_shift     - (bitslip build only) rotation 0..9, >9 treated as 9
module jesd204_tx_comma_gen
    import jesd204_soft_pcs_pkg::*;
#(
    parameter int unsigned DATA_PATH_WIDTH = 4,
    parameter int unsigned CGS_CNT_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               cgs_req,
    input  logic [CGS_CNT_WIDTH-1:0]           min_cgs_beats,
    input  logic [SYM_W*DATA_PATH_WIDTH-1:0]   in_data,
    input  logic                               in_valid,
`ifdef JESD204_TX_COMMA_BITSLIP_EN
    input  logic [3:0]                         slip_shift,
`endif
    output logic                               in_ready,
    output logic [SYM_W*DATA_PATH_WIDTH-1:0]   out_data,
    output logic                               cgs_active,
    output logic                               rd_out,
    output logic                               disparity_err
);

    localparam int unsigned BW = SYM_W * DATA_PATH_WIDTH;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [CGS_CNT_WIDTH-1:0]   r_cgs_cnt;
    logic [CGS_CNT_WIDTH-1:0]   w_cgs_cnt_next;
    logic [CGS_CNT_WIDTH-1:0]   w_cgs_cnt_inc;
    logic                       r_rd;
    logic [BW-1:0]              r_out_data;
    logic                       r_disp_err;

    logic                       w_fwd;
    logic [BW-1:0]              w_beat;
    logic [BW-1:0]              w_out_next;
    logic [DATA_PATH_WIDTH:0]   w_rd_chain;
    logic [DATA_PATH_WIDTH-1:0] w_sym_err;

    assign w_fwd         = (r_state == ST_DATA) && in_valid;
    assign w_rd_chain[0] = r_rd;

    // Each slot picks its comma variant from the RD left by the previous
    // slot, so commas alternate within a beat and across beats.
    for (genvar g = 0; g < DATA_PATH_WIDTH; g++) begin : g_slot
        logic [SYM_W-1:0] w_sym;

        assign w_sym = w_fwd ? in_data[g*SYM_W +: SYM_W]
                             : (w_rd_chain[g] ? PATTERN_P : PATTERN_N);
        assign w_beat[g*SYM_W +: SYM_W] = w_sym;

        jesd204_disparity_track u_track (
            .i_sym (w_sym),
            .i_rd  (w_rd_chain[g]),
            .o_rd  (w_rd_chain[g+1]),
            .o_err (w_sym_err[g])
        );
    end

`ifdef JESD204_TX_COMMA_BITSLIP_EN
    logic [3:0] w_slip;

    assign w_slip = (slip_shift > 4'd9) ? 4'd9 : slip_shift;

    // Rotate right by n: output bit i takes symbol bit (i + n) mod 10.
    always_comb begin
        w_out_next = '0;
        for (int unsigned s = 0; s < DATA_PATH_WIDTH; s++) begin
            for (int unsigned i = 0; i < SYM_W; i++) begin
                w_out_next[s*SYM_W + i] =
                    w_beat[s*SYM_W + ((i + int'(w_slip)) % SYM_W)];
            end
        end
    end
`else
    assign w_out_next = w_beat;
`endif

    // The beat on which the state changes is still emitted in the old mode:
    // output muxing uses r_state, only the next state changes.
    always_comb begin
        w_next_state   = r_state;
        w_cgs_cnt_next = r_cgs_cnt;
        w_cgs_cnt_inc  = (&r_cgs_cnt) ? r_cgs_cnt
                       : r_cgs_cnt + {{(CGS_CNT_WIDTH-1){1'b0}}, 1'b1};
        case (r_state)
            ST_CGS: begin
                // Compare against the count including this beat, so
                // min_cgs_beats is the number of comma beats emitted.
                w_cgs_cnt_next = w_cgs_cnt_inc;
                if (!cgs_req && (w_cgs_cnt_inc >= min_cgs_beats)) begin
                    w_next_state   = ST_DATA;
                    w_cgs_cnt_next = '0;
                end
            end
            ST_DATA: begin
                w_cgs_cnt_next = '0;
                if (cgs_req) begin
                    w_next_state = ST_CGS;
                end
            end
            default: begin
                w_next_state   = ST_CGS;
                w_cgs_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_CGS;
            r_cgs_cnt  <= '0;
            r_rd       <= 1'b0;
            r_out_data <= {DATA_PATH_WIDTH{PATTERN_N}};
            r_disp_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cgs_cnt  <= w_cgs_cnt_next;
            r_rd       <= w_rd_chain[DATA_PATH_WIDTH];
            r_out_data <= w_out_next;
            r_disp_err <= w_fwd && (|w_sym_err);
        end
    end

    assign in_ready      = (r_state == ST_DATA);
    assign cgs_active    = (r_state == ST_CGS);
    assign rd_out        = r_rd;
    assign out_data      = r_out_data;
    assign disparity_err = r_disp_err;

endmodule

// File: tb/tb_jesd204_tx_comma_gen.sv
// tb_jesd204_tx_comma_gen
//   Self-checking bench for jesd204_tx_comma_gen (DATA_PATH_WIDTH = 4).
//   A beat-level reference model derives expected symbols, RD and error
//   flags from symbol weights; directed steps are followed by random beats.
module tb_jesd204_tx_comma_gen;

    localparam int DPW = 4;
    localparam int CW  = 8;

    localparam logic [9:0] P   = 10'b1010000011;
    localparam logic [9:0] N   = 10'b0101111100;
    localparam logic [9:0] S6A = 10'b1100111010;
    localparam logic [9:0] S4  = 10'b1000110001;
    localparam logic [9:0] S5  = 10'b1010101010;
    localparam logic [9:0] S6B = 10'b0111001101;
    localparam logic [9:0] S5B = 10'b0011110001;
    localparam logic [9:0] S3  = 10'b0100011000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cgs_req;
    logic [7:0]  min_cgs_beats;
    logic [39:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] out_data;
    logic        cgs_active;
    logic        rd_out;
    logic        disparity_err;
`ifdef JESD204_TX_COMMA_BITSLIP_EN
    logic [3:0]  slip_shift;
`endif

    always #5 clk = ~clk;

    jesd204_tx_comma_gen #(
        .DATA_PATH_WIDTH (DPW),
        .CGS_CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cgs_req       (cgs_req),
        .min_cgs_beats (min_cgs_beats),
        .in_data       (in_data),
        .in_valid      (in_valid),
`ifdef JESD204_TX_COMMA_BITSLIP_EN
        .slip_shift    (slip_shift),
`endif
        .in_ready      (in_ready),
        .out_data      (out_data),
        .cgs_active    (cgs_active),
        .rd_out        (rd_out),
        .disparity_err (disparity_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_data;
    int          m_cnt;
    bit          m_rd;
    logic [39:0] m_out;
    bit          m_err;

    logic [9:0] tbl [6] = '{S6A, S4, S5, S6B, S5B, S3};

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] rot(input logic [9:0] s, input int n);
        int k;
        logic [19:0] d;
        k = (n > 9) ? 9 : n;
        d = {s, s};
        return d[k +: 10];
    endfunction

    task automatic model_reset();
        m_data = 0;
        m_cnt  = 0;
        m_rd   = 0;
        m_out  = {4{N}};
        m_err  = 0;
    endtask

    task automatic check_reset_values(input string ctx);
        check({ctx, "_out_data"}, out_data, {4{N}});
        check1({ctx, "_rd_out"}, rd_out, 1'b0);
        check1({ctx, "_cgs_active"}, cgs_active, 1'b1);
        check1({ctx, "_in_ready"}, in_ready, 1'b0);
        check1({ctx, "_disparity_err"}, disparity_err, 1'b0);
    endtask

    // One beat: called at posedge+1 with inputs already applied.
    task automatic beat();
        bit fwd;
        bit rd;
        bit e;
        int n;
        int slip;
        logic [9:0] s;
        slip = 0;
`ifdef JESD204_TX_COMMA_BITSLIP_EN
        slip = int'(slip_shift);
`endif
        check1("in_ready", in_ready, m_data);
        check1("cgs_active", cgs_active, !m_data);
        fwd = m_data && in_valid;
        rd  = m_rd;
        e   = 0;
        for (int i = 0; i < DPW; i++) begin
            s = fwd ? in_data[i*10 +: 10] : (rd ? P : N);
            n = $countones(s);
            if (fwd && (n < 4 || n > 6 || (n == 6 && rd) || (n == 4 && !rd))) e = 1;
            if (n >= 6) rd = 1;
            else if (n <= 4) rd = 0;
            m_out[i*10 +: 10] = rot(s, slip);
        end
        m_rd  = rd;
        m_err = e;
        if (!m_data) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (!cgs_req && m_cnt >= int'(min_cgs_beats)) begin
                m_data = 1;
                m_cnt  = 0;
            end
        end else if (cgs_req) begin
            m_data = 0;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        check("out_data", out_data, m_out);
        check1("rd_out", rd_out, m_rd);
        check1("disparity_err", disparity_err, m_err);
    endtask

    task automatic drive(input logic req, input logic v, input logic [39:0] d);
        cgs_req  = req;
        in_valid = v;
        in_data  = d;
        beat();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cgs_beats;
        int k;
        logic [39:0] d;
        logic [9:0]  nv;

        resetn        = 1'b0;
        cgs_req       = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        min_cgs_beats = 8'd5;
`ifdef JESD204_TX_COMMA_BITSLIP_EN
        slip_shift    = 4'd0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        resetn = 1'b1;

        // CGS hold: N,P,N,P in every beat, RD- at beat end
        repeat (4) drive(1'b1, 1'b0, '0);
        check("cgs_pattern", out_data, {P, N, P, N});
        check1("cgs_rd", rd_out, 1'b0);

        // fresh CGS with min 5, cgs_req falls after two beats
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
        model_reset();
        cgs_beats = 0;
        repeat (2) begin
            drive(1'b1, 1'b0, '0);
            cgs_beats++;
        end
        k = 0;
        while (cgs_active === 1'b1 && k < 50) begin
            drive(1'b0, 1'b0, '0);
            cgs_beats++;
            k++;
        end
        check("cgs_beats_min5", 40'(cgs_beats), 40'd5);
        check1("ready_after_cgs", in_ready, 1'b1);

        // balanced-chain data from RD-
        drive(1'b0, 1'b1, {S6B, S5, S4, S6A});
        check("data_fwd", out_data, {S6B, S5, S4, S6A});
        check1("data_rd", rd_out, 1'b1);
        check1("data_noerr", disparity_err, 1'b0);

        // 6-ones symbol at RD+
        drive(1'b0, 1'b1, {S5, S5, S5, S6A});
        check("err_fwd", out_data, {S5, S5, S5, S6A});
        check1("err_pulse", disparity_err, 1'b1);
        check1("err_rd", rd_out, 1'b1);

        // idle fill from RD+
        repeat (3) drive(1'b0, 1'b0, {$urandom, $urandom});
        check("idle_commas", out_data, {N, P, N, P});
        check1("idle_stay_data", cgs_active, 1'b0);

        // back to CGS, counter restarts
        min_cgs_beats = 8'd3;
        drive(1'b1, 1'b0, '0);
        check1("reenter_cgs", cgs_active, 1'b1);
        cgs_beats = 0;
        k = 0;
        while (cgs_active === 1'b1 && k < 50) begin
            drive(1'b0, 1'b0, '0);
            cgs_beats++;
            k++;
        end
        check("cgs_beats_min3", 40'(cgs_beats), 40'd3);

        // random traffic with a mid-run asynchronous reset
        for (int b = 0; b < 400; b++) begin
            if (b % 100 == 0) min_cgs_beats = 8'($urandom_range(0, 3));
            for (int i = 0; i < DPW; i++) begin
                if ($urandom_range(0, 7) == 0) d[i*10 +: 10] = 10'($urandom);
                else d[i*10 +: 10] = tbl[$urandom_range(0, 5)];
            end
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), d);
            if (b == 200) begin
                #2 resetn = 1'b0;
                #1 check_reset_values("midreset");
                @(posedge clk);
                #1 resetn = 1'b1;
                model_reset();
            end
        end

`ifdef JESD204_TX_COMMA_BITSLIP_EN
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
        model_reset();
        slip_shift = 4'd3;
        drive(1'b1, 1'b0, '0);
        nv = N;
        check("slip3_slot0", 40'(out_data[9:0]), 40'({nv[2:0], nv[9:3]}));
        slip_shift = 4'd12;
        drive(1'b1, 1'b0, '0);
        slip_shift = 4'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jesd204_tx_comma_gen.md
Name: jesd204_tx_comma_gen

Overview:
- Transmit-side soft-PCS block that drives 10b symbols toward the serializer.
- During code-group synchronisation (CGS) it emits K28.5 commas with correct running-disparity (RD) alternation, so the receive-side pattern aligner can lock.
- In DATA it forwards pre-encoded 10b symbols, tracks RD and flags disparity violations.
- Sits between the TX 8b10b encoder output and the transceiver/serializer parallel interface.

Parameters:
- DATA_PATH_WIDTH, 4, number of 10b symbols per beat (1, 2 or 4).
- CGS_CNT_WIDTH, 8, width of the CGS beat counter and of min_cgs_beats.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- cgs_req  in  1  high = request/hold CGS; low = permit DATA.
- min_cgs_beats  in  CGS_CNT_WIDTH  minimum comma beats before leaving CGS; quasi-static.
- in_data  in  10*DATA_PATH_WIDTH  encoded symbols; symbol 0 in [9:0], sent first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  10*DATA_PATH_WIDTH  symbols to serializer; bit 0 of each symbol transmitted first.
- cgs_active  out  1  high while in CGS state.
- rd_out  out  1  running disparity after last emitted symbol (1 = RD+).
- disparity_err  out  1  one-beat pulse: a forwarded symbol violated RD rules.

Behaviour:
- Constants: PATTERN_P = 10'b1010000011 (4 ones, sent at RD+, leaves RD-); PATTERN_N = 10'b0101111100 (6 ones, sent at RD-, leaves RD+).
- Reset values: out_data = all symbols PATTERN_N, rd_out = 0 (RD-), cgs_active = 1, in_ready = 0, disparity_err = 0, state = CGS, cgs_cnt = 0.
- FSM, two states:
  - CGS: every beat emits one comma per symbol slot. The variant is chosen per slot by the RD chained through the beat (RD- -> PATTERN_N, RD+ -> PATTERN_P), so commas alternate P/N. cgs_cnt increments, saturating at all-ones. Go to DATA when cgs_req = 0 and cgs_cnt >= min_cgs_beats. With min_cgs_beats = 0, leave after one CGS beat.
  - DATA: in_ready = 1. On in_valid & in_ready, symbols are registered to out_data (latency 1 clk). If in_valid = 0, emit RD-correct commas (idle fill) and stay in DATA. cgs_req = 1 -> CGS on next beat; cgs_cnt cleared on entry.
- Transition beat: the beat where the state changes is emitted in the old state's mode. in_ready is combinational from state, so no input is dropped.
- RD tracking per symbol, chained slot 0 -> DATA_PATH_WIDTH-1, registered at beat end:
  - ones = 6 -> RD+
  - ones = 4 -> RD-
  - ones = 5 -> unchanged
- disparity_err is asserted for one beat if any forwarded symbol in the beat has:
  - ones not in {4,5,6}, or
  - 6 ones while RD+, or
  - 4 ones while RD-.
  The symbol is still forwarded; RD is updated as ones >= 6 -> RD+, ones <= 4 -> RD-.
- Commas never raise disparity_err.
- resetn asserted mid-operation: all outputs return asynchronously to reset values; on release the block restarts in CGS with RD-.

Optional Feature:
- Macro JESD204_TX_COMMA_BITSLIP_EN.
- Defined: adds input slip_shift [3:0]. Each out_data symbol is rotated right by slip_shift (0..9; values >= 10 treated as 9), where rotation by n = {s[n-1:0], s[9:n]}. This is a test aid for exercising RX aligners. RD tracking uses unrotated symbols.
- Undefined: no port, no rotation, zero extra logic.

Decomposition:
- Package jesd204_soft_pcs_pkg: PATTERN_P, PATTERN_N, state enum encoding (CGS, DATA), symbol width constant 10.
- Sub-module jesd204_disparity_track: combinational, one 10b symbol plus rd_in -> rd_next, err. Instantiated DATA_PATH_WIDTH times in a chain.

Test Plan:
- Reset, cgs_req = 1, DATA_PATH_WIDTH = 4 -> out_data alternates N,P,N,P per beat; rd_out = 0 at each beat end; in_ready = 0; disparity_err never set.
- min_cgs_beats = 5, cgs_req falls at cycle 2 -> cgs_active drops after exactly 5 CGS beats; in_ready = 1 the following cycle.
- DATA, in_valid with symbols of ones {6,4,5,6} from RD- -> forwarded 1 cycle later unchanged; rd_out = 1; no error.
- DATA from RD+, symbol with 6 ones -> disparity_err pulses 1 beat; rd_out = 1; symbol still on out_data.
- DATA, in_valid = 0 for 3 beats -> RD-correct commas emitted, state stays DATA; then cgs_req = 1 -> CGS next beat; cgs_cnt restarts at 0.
- With JESD204_TX_COMMA_BITSLIP_EN, slip_shift = 3, CGS at RD- -> slot 0 equals {PATTERN_N[2:0], PATTERN_N[9:3]}; feeding out_data to jesd204_pattern_align recovers PATTERN_N.
